// File: rtl/reg_target_io.sv
// Register-mapped target IO block: per-channel drive modes, a one-shot low pulse
// on a selected channel, and synchronized pin readback on a byte-wide register bus.
module reg_target_io #(
  parameter int         NIO         = 8,
  parameter int         PULSE_W     = 16,
  parameter logic [5:0] ADDR_MODE   = 6'd56,
  parameter logic [5:0] ADDR_PULSE  = 6'd57,
  parameter logic [5:0] ADDR_STATUS = 6'd58
) (
  input  logic             clk_usb,
  input  logic             reset_i,
  input  logic [5:0]       reg_address,
  input  logic [15:0]      reg_bytecnt,
  input  logic [7:0]       reg_datai,
  output logic [7:0]       reg_datao,
  input  logic             reg_read,
  input  logic             reg_write,
  input  logic             reg_addrvalid,
  output logic [15:0]      reg_hyplen,
  input  logic [NIO-1:0]   io_in,
  input  logic [NIO-1:0]   src_i,
  input  logic             target_highz,
  output logic [NIO-1:0]   io_out,
  output logic [NIO-1:0]   io_oe,
  output logic             pulse_busy
);

  localparam int MODE_BYTES = (NIO + 3) / 4;
  localparam int STAT_BYTES = (NIO + 7) / 8;

  typedef enum logic [0:0] {IDLE = 1'b0, PULSE = 1'b1} state_t;

  state_t               state_r;
  logic [2*NIO-1:0]     mode_r;
  logic [15:0]          len_r;
  logic [7:0]           idx_r;
  logic [7:0]           pulse_ch_r;
  logic [PULSE_W-1:0]   cnt_r;
  logic [NIO-1:0]       sync1_r;
  logic [NIO-1:0]       sync2_r;

  logic                 wr_mode_s;
  logic                 wr_pulse_s;
  logic                 start_s;
  logic [8*MODE_BYTES-1:0] mode_pad_s;
  logic [8*MODE_BYTES-1:0] mode_wr_s;
  logic [8*STAT_BYTES+7:0] stat_s;
  logic [NIO-1:0]       drv_oe_s;
  logic [NIO-1:0]       drv_out_s;
  logic [NIO-1:0]       pulse_hit_s;
  logic [7:0]           sel_s;
  logic [15:0]          hyplen_s;

  function automatic logic [7:0] pick_byte(input logic [255:0] v, input logic [15:0] idx,
                                           input int nbytes);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 32; b++) begin
      r = ((b < nbytes) && (idx == 16'(b))) ? v[8*b +: 8] : r;
    end
    return r;
  endfunction

  assign wr_mode_s  = reg_write && reg_addrvalid && (reg_address == ADDR_MODE);
  assign wr_pulse_s = reg_write && reg_addrvalid && (reg_address == ADDR_PULSE);
  // A start needs a non-zero stored length and an in-range channel; anything else only stores the index.
  assign start_s    = wr_pulse_s && (reg_bytecnt == 16'd2) && (state_r == IDLE) &&
                      (len_r[PULSE_W-1:0] != '0) && (32'(reg_datai) < NIO);
  assign pulse_busy = (state_r == PULSE);

  // Mode register image with the addressed byte replaced by the bus data.
  always_comb begin
    mode_pad_s = '0;
    mode_pad_s[2*NIO-1:0] = mode_r;
    mode_wr_s = mode_pad_s;
    for (int b = 0; b < MODE_BYTES; b++) begin
      mode_wr_s[8*b +: 8] = (reg_bytecnt == 16'(b)) ? reg_datai : mode_pad_s[8*b +: 8];
    end
  end

  // Bus-writable configuration registers.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      mode_r <= '0;
      len_r  <= 16'h0000;
      idx_r  <= 8'h00;
    end else begin
      if (wr_mode_s) begin
        mode_r <= mode_wr_s[2*NIO-1:0];
      end
      if (wr_pulse_s) begin
        case (reg_bytecnt)
          16'd0:   len_r[7:0]  <= reg_datai;
          16'd1:   len_r[15:8] <= reg_datai;
          16'd2:   idx_r       <= reg_datai;
          default: ;
        endcase
      end
    end
  end

  // Pulse FSM; the channel is latched at start so later index writes cannot move a running pulse.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      pulse_ch_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r    <= PULSE;
            cnt_r      <= len_r[PULSE_W-1:0];
            pulse_ch_r <= reg_datai;
          end
        end
        PULSE: begin
          if (cnt_r == PULSE_W'(1)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r - PULSE_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous pin levels.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= io_in;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel drive from the mode bits.
  always_comb begin
    drv_oe_s  = '0;
    drv_out_s = '0;
    for (int k = 0; k < NIO; k++) begin
      case (mode_r[2*k +: 2])
        2'b01: begin drv_oe_s[k] = 1'b1; drv_out_s[k] = 1'b0;     end
        2'b10: begin drv_oe_s[k] = 1'b1; drv_out_s[k] = 1'b1;     end
        2'b11: begin drv_oe_s[k] = 1'b1; drv_out_s[k] = src_i[k]; end
        default: begin drv_oe_s[k] = 1'b0; drv_out_s[k] = 1'b0;   end
      endcase
    end
  end

  // Pulse overrides mode on its channel; high-Z overrides everything but leaves the counter running.
  always_comb begin
    for (int k = 0; k < NIO; k++) begin
      pulse_hit_s[k] = pulse_busy && (pulse_ch_r == 8'(k));
      io_oe[k]       = !target_highz && (pulse_hit_s[k] || drv_oe_s[k]);
      io_out[k]      = !target_highz && !pulse_hit_s[k] && drv_out_s[k];
    end
  end

  // Status image: synchronized pins, then a byte holding the busy flag.
  always_comb begin
    stat_s = '0;
    stat_s[NIO-1:0] = sync2_r;
    stat_s[8*STAT_BYTES] = pulse_busy;
  end

  // Address decode for readback data and register length.
  always_comb begin
    sel_s    = 8'h00;
    hyplen_s = 16'h0000;
    if (reg_address == ADDR_MODE) begin
      hyplen_s = 16'(MODE_BYTES);
      sel_s    = pick_byte(256'(mode_r), reg_bytecnt, MODE_BYTES);
    end else if (reg_address == ADDR_PULSE) begin
      hyplen_s = 16'd3;
      sel_s    = pick_byte(256'({idx_r, len_r}), reg_bytecnt, 3);
    end else if (reg_address == ADDR_STATUS) begin
      hyplen_s = 16'(STAT_BYTES + 1);
      sel_s    = pick_byte(256'(stat_s), reg_bytecnt, STAT_BYTES + 1);
    end else begin
      hyplen_s = 16'h0000;
      sel_s    = 8'h00;
    end
  end

  assign reg_datao  = reg_read ? sel_s : 8'h00;
  assign reg_hyplen = hyplen_s;

endmodule

// File: tb/tb_reg_target_io.sv
// Directed-plus-random bench for reg_target_io (NIO=8) against a cycle-level
// behavioural model of modes, pulse, synchronizer and readback.
module tb_reg_target_io;
  localparam int NIO = 8;

  logic        clk_usb = 1'b0;
  logic        reset_i;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read, reg_write, reg_addrvalid;
  logic [15:0] reg_hyplen;
  logic [7:0]  io_in, src_i, io_out, io_oe;
  logic        target_highz, pulse_busy;

  int total = 0;
  int passed = 0;

  // model state
  logic [1:0]  mode_m [NIO];
  logic [15:0] len_m;
  logic [7:0]  idx_m;
  int          rem_m, ch_m;
  logic [7:0]  s1_m, s2_m;

  always #5 clk_usb = ~clk_usb;

  reg_target_io #(.NIO(NIO)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai), .reg_datao(reg_datao),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .reg_hyplen(reg_hyplen), .io_in(io_in), .src_i(src_i),
    .target_highz(target_highz), .io_out(io_out), .io_oe(io_oe),
    .pulse_busy(pulse_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NIO; k++) mode_m[k] = 2'b00;
    len_m = 16'h0000; idx_m = 8'h00; rem_m = 0; ch_m = 0; s1_m = 8'h00; s2_m = 8'h00;
  endtask

  // What the block does at a rising edge, given the inputs present before it.
  task automatic model_edge();
    bit hit;
    if (reset_i) begin
      model_reset();
      return;
    end
    hit = reg_write && reg_addrvalid;
    if (rem_m > 0) rem_m--;
    else if (hit && reg_address == 6'd57 && reg_bytecnt == 16'd2 &&
             len_m != 16'h0000 && int'(reg_datai) < NIO) begin
      rem_m = int'(len_m);
      ch_m  = int'(reg_datai);
    end
    if (hit && reg_address == 6'd56 && reg_bytecnt < 16'd2)
      for (int j = 0; j < 4; j++) mode_m[int'(reg_bytecnt) * 4 + j] = reg_datai[2*j +: 2];
    if (hit && reg_address == 6'd57) begin
      if (reg_bytecnt == 16'd0) len_m[7:0] = reg_datai;
      else if (reg_bytecnt == 16'd1) len_m[15:8] = reg_datai;
      else if (reg_bytecnt == 16'd2) idx_m = reg_datai;
    end
    s2_m = s1_m;
    s1_m = io_in;
  endtask

  task automatic check_outputs();
    logic [7:0] eo, ex;
    for (int k = 0; k < NIO; k++) begin
      eo[k] = (mode_m[k] != 2'b00);
      ex[k] = (mode_m[k] == 2'b10) || (mode_m[k] == 2'b11 && src_i[k]);
      if (rem_m > 0 && ch_m == k) begin eo[k] = 1'b1; ex[k] = 1'b0; end
      if (target_highz) begin eo[k] = 1'b0; ex[k] = 1'b0; end
    end
    chk("io_oe", io_oe, eo);
    chk("io_out", io_out, ex);
    chk("pulse_busy", pulse_busy, (rem_m > 0));
  endtask

  task automatic cycle();
    @(posedge clk_usb);
    model_edge();
    @(negedge clk_usb);
    check_outputs();
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_write = 1'b1; reg_addrvalid = 1'b1;
    cycle();
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  function automatic logic [7:0] exp_byte(input logic [5:0] a, input logic [15:0] bc);
    logic [7:0] r;
    r = 8'h00;
    if (a == 6'd56 && bc < 16'd2)
      for (int j = 0; j < 4; j++) r[2*j +: 2] = mode_m[int'(bc) * 4 + j];
    else if (a == 6'd57 && bc == 16'd0) r = len_m[7:0];
    else if (a == 6'd57 && bc == 16'd1) r = len_m[15:8];
    else if (a == 6'd57 && bc == 16'd2) r = idx_m;
    else if (a == 6'd58 && bc == 16'd0) r = s2_m;
    else if (a == 6'd58 && bc == 16'd1) r = {7'd0, rem_m > 0};
    return r;
  endfunction

  function automatic logic [15:0] exp_len(input logic [5:0] a);
    return (a == 6'd56) ? 16'd2 : (a == 6'd57) ? 16'd3 : (a == 6'd58) ? 16'd2 : 16'd0;
  endfunction

  task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] bc);
    reg_address = a; reg_bytecnt = bc; reg_read = 1'b1;
    #1;
    chk(tag, reg_datao, exp_byte(a, bc));
    chk({tag, "_len"}, reg_hyplen, exp_len(a));
    reg_read = 1'b0;
    #1;
    chk({tag, "_noread"}, reg_datao, 8'h00);
  endtask

  initial begin
    int busy_cnt;
    int op;
    reset_i = 1'b1; reg_address = 6'd0; reg_bytecnt = 16'd0; reg_datai = 8'h00;
    reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
    io_in = 8'h00; src_i = 8'h00; target_highz = 1'b0;
    model_reset();
    cycle(); cycle();
    chk("reset_oe", io_oe, 8'h00);
    chk("reset_busy", pulse_busy, 1'b0);
    reset_i = 1'b0;
    cycle();

    // modes E4,00
    wr(6'd56, 16'd0, 8'hE4);
    wr(6'd56, 16'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      src_i = 8'($urandom);
      #1;
      check_outputs();
    end
    src_i = 8'h08; #1; chk("ch3_pass_hi", {io_oe[3], io_out[3]}, 2'b11);
    src_i = 8'h00; #1; chk("ch3_pass_lo", {io_oe[3], io_out[3]}, 2'b10);
    chk("mode_oe", io_oe, 8'h0E);
    rd("mode_b0", 6'd56, 16'd0);
    rd("mode_b1", 6'd56, 16'd1);
    rd("mode_oob", 6'd56, 16'd2);
    wr(6'd56, 16'd5, 8'hFF);
    chk("mode_oob_wr", io_oe, 8'h0E);

    // length 5 on channel 3
    wr(6'd57, 16'd0, 8'h05);
    wr(6'd57, 16'd1, 8'h00);
    wr(6'd57, 16'd2, 8'h03);
    busy_cnt = 32'(pulse_busy);
    for (int i = 0; i < 8; i++) begin
      src_i = 8'($urandom);
      cycle();
      busy_cnt += 32'(pulse_busy);
    end
    chk("pulse5_len", busy_cnt, 5);
    rd("pulse_b2", 6'd57, 16'd2);

    // 10-cycle pulse with a second start ignored
    wr(6'd57, 16'd0, 8'h0A);
    wr(6'd57, 16'd2, 8'h01);
    busy_cnt = 32'(pulse_busy);
    wr(6'd57, 16'd2, 8'h03);
    busy_cnt += 32'(pulse_busy);
    for (int i = 0; i < 12; i++) begin cycle(); busy_cnt += 32'(pulse_busy); end
    chk("pulse10_len", busy_cnt, 10);
    wr(6'd57, 16'd2, 8'h09);
    chk("idx9_nostart", pulse_busy, 1'b0);
    wr(6'd57, 16'd0, 8'h00);
    wr(6'd57, 16'd2, 8'h02);
    chk("len0_nostart", pulse_busy, 1'b0);

    // 20-cycle pulse under high-Z, released at cycle 12
    wr(6'd57, 16'd0, 8'h14);
    target_highz = 1'b1;
    wr(6'd57, 16'd2, 8'h03);
    for (int i = 2; i <= 11; i++) cycle();
    chk("highz_oe", io_oe, 8'h00);
    target_highz = 1'b0;
    #1;
    chk("highz_release", {io_oe[3], io_out[3]}, 2'b10);
    for (int i = 12; i <= 22; i++) cycle();

    // synchronizer latency
    io_in = 8'hA5;
    cycle();
    rd("sync_1edge", 6'd58, 16'd0);
    cycle();
    rd("sync_2edge", 6'd58, 16'd0);
    chk("sync_val", exp_byte(6'd58, 16'd0), 8'hA5);
    reg_address = 6'd10; reg_read = 1'b1; #1;
    chk("unaddr_data", reg_datao, 8'h00);
    chk("unaddr_len", reg_hyplen, 16'h0000);
    reg_read = 1'b0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      src_i = 8'($urandom); io_in = 8'($urandom);
      target_highz = ($urandom_range(0, 7) == 0);
      op = $urandom_range(0, 9);
      case (op)
        0: wr(6'd56, 16'($urandom_range(0, 2)), 8'($urandom));
        1: wr(6'd57, 16'd0, 8'($urandom_range(0, 12)));
        2: wr(6'd57, 16'd1, ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
        3: wr(6'd57, 16'd2, 8'($urandom_range(0, 9)));
        4: begin
          rd("rand_rd", 6'(55 + $urandom_range(0, 4)), 16'($urandom_range(0, 3)));
          cycle();
        end
        default: cycle();
      endcase
    end

    // reset in the middle of a pulse
    target_highz = 1'b0;
    wr(6'd56, 16'd0, 8'hAA);
    wr(6'd57, 16'd0, 8'h0A);
    wr(6'd57, 16'd1, 8'h00);
    wr(6'd57, 16'd2, 8'h04);
    cycle(); cycle();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    chk("rst_oe", io_oe, 8'h00);
    chk("rst_out", io_out, 8'h00);
    chk("rst_busy", pulse_busy, 1'b0);
    rd("rst_mode", 6'd56, 16'd0);
    for (int i = 0; i < 12; i++) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_target_io.md
REG_TARGET_IO -- requirements
Module: reg_target_io

Interface
REQ-001 SHALL have parameter NIO, default 8, meaning number of target IO channels (1..32).
REQ-002 SHALL have parameter PULSE_W, default 16, meaning pulse-length counter width in bits (8..16).
REQ-003 SHALL have parameters ADDR_MODE, ADDR_PULSE, ADDR_STATUS, defaults 6'd56, 6'd57, 6'd58, meaning register addresses.
REQ-004 SHALL have port clk_usb  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports reg_address input 6, reg_bytecnt input 16, reg_datai input 8, reg_read input 1, reg_write input 1, reg_addrvalid input 1: standard register bus.
REQ-007 SHALL have ports reg_datao output 8, reg_hyplen output 16: readback byte and length of addressed register, both 0 when not addressed.
REQ-008 SHALL have port io_in  input  NIO  raw pin levels, asynchronous to clk_usb.
REQ-009 SHALL have port src_i  input  NIO  per-channel passthrough sources.
REQ-010 SHALL have port target_highz  input  1  forces all channels undriven.
REQ-011 SHALL have ports io_out output NIO, io_oe output NIO: per-channel drive value and enable; tristate built outside.
REQ-012 SHALL have port pulse_busy  output  1  high while a pulse is in progress.

Function
REQ-013 Mode register SHALL hold 2 bits per channel, channel k at bits [2k+1:2k], ceil(NIO/4) bytes, byte selected by reg_bytecnt; out-of-range bytes ignored on write, read 0.
REQ-014 Modes SHALL be: 00 high-Z (oe=0, out=0); 01 drive 0; 10 drive 1; 11 passthrough (oe=1, out=src_i[k], combinational from src_i).
REQ-015 A write SHALL take effect when reg_write && reg_addrvalid && reg_address matches, updating the register on that clock edge; outputs reflect it the next cycle.
REQ-016 Pulse register SHALL be 3 bytes: bytes 0-1 length (little-endian, truncated to PULSE_W), byte 2 channel index.
REQ-017 Writing byte 2 SHALL start a pulse only in IDLE, with length != 0 and index < NIO; otherwise the write stores the index and starts nothing.
REQ-018 FSM SHALL have states IDLE and PULSE; IDLE->PULSE on valid start; counter loads length and decrements each cycle in PULSE; PULSE->IDLE the cycle the counter reaches 1.
REQ-019 Pulse of length L SHALL drive the selected channel oe=1, out=0 for exactly L cycles, starting the cycle after the start write; pulse_busy high for those same L cycles.
REQ-020 Start writes during PULSE SHALL be ignored; mode writes during PULSE SHALL update the register, and the pulsed channel follows its new mode only after the pulse ends.
REQ-021 target_highz=1 SHALL force io_oe=0 and io_out=0 on all channels combinationally, without stopping the pulse counter.
REQ-022 io_in SHALL pass through a two-flop synchronizer per channel; status register SHALL return synchronized levels, ceil(NIO/8) bytes, unused bits 0, plus byte ceil(NIO/8) bit0 = pulse_busy.
REQ-023 reg_datao SHALL be combinational: addressed byte when reg_read && reg_address matches, else 8'h00, so it may be OR-combined with other register blocks.
REQ-024 reg_hyplen SHALL equal byte count of the register at reg_address (mode ceil(NIO/4), pulse 3, status ceil(NIO/8)+1), else 0.

Reset
REQ-025 reset_i high at a clock edge SHALL clear mode and pulse registers, synchronizers and counter, enter IDLE, give io_oe=0, io_out=0, pulse_busy=0 next cycle.
REQ-026 reset_i asserted mid-pulse SHALL abort it; no residual drive after reset deasserts.

Verification
REQ-027 NIO=8: write mode bytes 0x E4, 0x00 -> ch0 oe=0; ch1 oe=1 out=0; ch2 oe=1 out=1; ch3 out tracks src_i[3]; ch4-7 oe=0.
REQ-028 Pulse length 0x0005, index 3 -> ch3 oe=1 out=0 for exactly 5 cycles, pulse_busy 5 cycles, ch3 then returns to its mode.
REQ-029 Second start at cycle 2 of a 10-cycle pulse -> ignored, pulse still ends at cycle 10; length 0 or index 9 -> no pulse.
REQ-030 target_highz=1 during a 20-cycle pulse -> io_oe=8'h00 throughout; deassert at cycle 12 -> pulse drive visible for cycles 12-20 only.
REQ-031 io_in toggled to 0xA5 -> status byte 0 reads 0xA5 no earlier than 2 cycles later; reg_datao=0 when unaddressed.
REQ-032 reset_i for one cycle at cycle 3 of a pulse -> all outputs 0, pulse_busy=0, mode reads 0.
